// File: rtl/pc_sequencer.sv
// pc_sequencer: control unit that steps the 8-bit ProgramCounter of the
// two-mode timer. It fetches one instruction byte from the asynchronous
// program ROM, then issues reset/load/inc commands to the PC for execute,
// timed wait, absolute jump, conditional jump and halt.
//
// Instruction byte layout (held in ir_out):
//   [7:6] opcode : 00 EXEC, 01 WAIT, 10 JUMP, 11 HALT
//   [5]   JUMP only: 1 = conditional on zero_flag
//   [5:0] WAIT only: number of cycles spent in WAIT (0 behaves as a no-op)
// A JUMP is followed by its target byte, which is either loaded into the
// PC (taken) or stepped over (not taken).
module pc_sequencer #(
  parameter logic [7:0] START_ADDR = 8'h00,
  parameter int         WAIT_W     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  input  logic       zero_flag,
  input  logic [7:0] pc_value,
  output logic       pc_reset,
  output logic       pc_load,
  output logic       pc_inc,
  output logic [7:0] pc_reset_val,
  output logic [7:0] pc_load_val,
  output logic       exec_en,
  output logic [7:0] ir_out,
  output logic       halted,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_WAIT      = 3'd3,
    S_FETCH_TGT = 3'd4,
    S_SKIP      = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [1:0] OP_EXEC = 2'b00;
  localparam logic [1:0] OP_WAIT = 2'b01;
  localparam logic [1:0] OP_JUMP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t            state_q, state_d;
  logic [7:0]        ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [1:0]        opcode;
  logic              jump_taken;

  // pc_value is exposed on the port list for observation only; it does not
  // influence sequencing because the PC itself owns the address.
  logic              unused_pc;
  assign unused_pc = ^pc_value;

  assign opcode     = ir_q[7:6];
  assign jump_taken = !ir_q[5] || zero_flag;

  // Next-state and PC command decode. Commands are decoded from the current
  // state (not registered) because the ROM is asynchronous: the byte seen on
  // instr belongs to the current PC and must be acted on in this cycle.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    wait_d      = wait_q;
    pc_reset    = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = 8'h00;
    exec_en     = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_IDLE: begin
        pc_reset = 1'b1;
        if (start) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        ir_d    = instr;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          OP_EXEC: begin
            exec_en = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end
          OP_WAIT: begin
            if (ir_q[5:0] == 6'd0) begin
              pc_inc  = 1'b1;
              state_d = S_FETCH;
            end else begin
              wait_d  = WAIT_W'(ir_q[5:0]);
              state_d = S_WAIT;
            end
          end
          OP_JUMP: begin
            // Both outcomes step onto the target byte first; the state
            // chosen here decides whether it is loaded or skipped.
            pc_inc  = 1'b1;
            state_d = jump_taken ? S_FETCH_TGT : S_SKIP;
          end
          OP_HALT: begin
            state_d = S_HALT;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end

      S_WAIT: begin
        // Exit on the last counted cycle so WAIT n spends exactly n cycles
        // here; the <= also guards a zero count left by a narrow WAIT_W.
        if (wait_q <= WAIT_W'(1)) begin
          wait_d  = '0;
          pc_inc  = 1'b1;
          state_d = S_FETCH;
        end else begin
          wait_d  = wait_q - WAIT_W'(1);
        end
      end

      S_FETCH_TGT: begin
        pc_load     = 1'b1;
        pc_load_val = instr;
        state_d     = S_FETCH;
      end

      S_SKIP: begin
        pc_inc  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, instruction register and wait counter; reset aborts any
  // operation in flight, including a partly counted WAIT or a jump.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir_q    <= 8'h00;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

  assign pc_reset_val = START_ADDR;
  assign ir_out       = ir_q;
  assign state_out    = state_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control unit that sequences the 8-bit ProgramCounter for the two-mode timer.
- Issues the PC's reset, load and inc commands, and the ResetVal and LoadVal values, from a fetched instruction byte.
- Implements execute, timed wait, absolute jump, conditional jump and halt.
- Sits between the program ROM and the ProgramCounter. The ROM is asynchronous and addressed by PCoutput, so instr is valid in the same cycle.

Parameters:
- START_ADDR, 8'h00, value driven on pc_reset_val; the PC restarts here.
- WAIT_W, 6, width of the wait-cycle counter (equal to instr[5:0]).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  run request; sampled only in IDLE and HALT.
- instr  input  8  ROM byte at the current PC.
- zero_flag  input  1  datapath zero flag; sampled in DECODE.
- pc_value  input  8  PCoutput of the ProgramCounter; debug/observe only.
- pc_reset  output  1  drives the PC reset input.
- pc_load  output  1  drives the PC load input.
- pc_inc  output  1  drives the PC inc input.
- pc_reset_val  output  8  drives ResetVal; constant START_ADDR.
- pc_load_val  output  8  drives LoadVal.
- exec_en  output  1  one-cycle execute strobe to the datapath.
- ir_out  output  8  instruction register.
- halted  output  1  high in HALT.
- state_out  output  3  current state encoding.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, WAIT=3, FETCH_TGT=4, SKIP=5, HALT=6. Codes 7 and above go to IDLE.
- Reset: reset==0 at a rising edge forces the following, from any state including mid-WAIT and mid-jump:
  - state=IDLE, ir_out=0, wait counter=0.
  - After that edge: pc_reset=1; pc_load, pc_inc, exec_en and halted are 0; pc_load_val=0.
- Outputs are decoded from state, ir_out and zero_flag. At most one of pc_reset, pc_load and pc_inc is high in any cycle.
- IDLE:
  - pc_reset=1.
  - start=1 → FETCH; otherwise stay.
- FETCH:
  - ir_out <= instr.
  - No PC command.
  - → DECODE.
- DECODE: opcode is ir_out[7:6].
  - 00 EXEC: exec_en=1, pc_inc=1 → FETCH. Two cycles per instruction.
  - 01 WAIT:
    - If ir_out[5:0]==0, act as EXEC without exec_en (pc_inc=1 → FETCH).
    - Otherwise counter <= ir_out[5:0], no PC command → WAIT.
  - 10 JUMP: ir_out[5]=1 makes it conditional.
    - Unconditional, or conditional with zero_flag==1: pc_inc=1 → FETCH_TGT.
    - Conditional with zero_flag==0: pc_inc=1 → SKIP.
  - 11 HALT: → HALT, no PC command.
- WAIT:
  - counter decrements each cycle.
  - In the cycle where counter==1: pc_inc=1 → FETCH.
  - WAIT n therefore occupies exactly n cycles in WAIT.
- FETCH_TGT:
  - pc_load=1, pc_load_val=instr (the target byte) → FETCH.
  - pc_load_val=0 in every other state.
- SKIP: pc_inc=1 → FETCH. The target byte is stepped over.
- HALT:
  - halted=1, no PC command.
  - start=1 → IDLE (PC re-reset); otherwise stay.
- start is ignored in FETCH, DECODE, WAIT, FETCH_TGT and SKIP.
- PC wrap from 0xFF to 0x00 is handled by the PC; the sequencer continues normally. A jump opcode at 0xFF takes its target from 0x00.
- zero_flag matters only in DECODE of a conditional jump.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then reset=1 with start=0 for 5 cycles → state_out=0, pc_reset=1 every cycle, PC=START_ADDR=0x00, exec_en=0.
- Exec and wait: ROM[0]=0x00, ROM[1]=0x43, ROM[2]=0xC0; pulse start.
  - Required: exec_en exactly 1 cycle; exactly 3 cycles with state_out=3.
  - PC sequence 0→1→2; halted=1 with PC=0x02.
- Jumps:
  - ROM[0]=0x80, ROM[1]=0x10, ROM[0x10]=0xC0 → pc_load=1 with pc_load_val=0x10 once; halt at PC=0x10.
  - ROM[0]=0xA0, ROM[1]=0x20, ROM[2]=0xC0, zero_flag=0 → SKIP visited, no pc_load, halt at PC=0x02.
  - Same program with zero_flag=1 → halt at PC=0x20.
- Mid-operation reset: ROM[0]=0x7F; assert reset=0 while state_out=3 and counter≈40 → next cycle state_out=0, pc_reset=1, and the WAIT does not resume after start.
- Halt restart and wrap:
  - In HALT, start=1 → IDLE, PC=0x00, program re-runs.
  - Separately, EXEC at 0xFF followed by ROM[0]=0xC0 → PC wraps 0xFF→0x00 and halts.
- Exclusivity: across all of the above, pc_reset+pc_load+pc_inc ≤ 1 every cycle (checked by assertion).
